cdma_decoder_array: RTL and testbench
=====================================

// Module: cdma_decoder_array
// PURPOSE
//  Multi-lane CDMA despreader. Decodes NUM_LANES codes in parallel from one shared summed channel.
//  Chips arrive under a valid qualifier, not free-running. The block tracks chip position internally.
//  Symbol resync is explicit. Results leave through a valid/ready interface with overrun detection.
//  Sits between the crossbar channel adder and the receiving ports; replaces per-port single-code decoders.
// PARAMETERS
//  NUM_LANES    4                              lanes (codes) decoded concurrently
//  CODE_BASE    0                              lane i uses CDMA_CODES[CODE_BASE+i]
//  CODE_LEN     CDMA_CODE_WIDTH                chips per symbol; power of two, >=2
//  LOG_CODE_LEN LOG_CODE_WIDTH                 log2(CODE_LEN)
//  CH_W         DATA_WIDTH+LOG_CODE_WIDTH      signed channel sample width
// PORTS
//  clk            in   1                       clock
//  rst            in   1                       synchronous reset, active high
//  chip_valid     in   1                       channel holds a valid chip this cycle
//  sym_start      in   1                       with chip_valid: this chip is chip 0 (resync)
//  channel        in   CH_W (signed)           summed channel sample
//  out_valid      out  1                       decoded[] holds one complete symbol
//  out_ready      in   1                       consumer accepts decoded[] when out_valid
//  decoded        out  NUM_LANES x DATA_WIDTH  signed per-lane data, lane 0 in LSBs
//  overrun        out  1                       sticky; a result was overwritten unconsumed
//  overrun_clr    in   1                       clears overrun
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset values:
//   - out_valid=0, overrun=0, decoded=0, chip index=0.
//   - All accumulators are don't-care; they are reloaded at chip 0.
//  Chip index idx counts 0..CODE_LEN-1 and advances only on chip_valid.
//   - It wraps to 0 after CODE_LEN-1.
//   - chip_valid&&sym_start forces the current chip to be chip 0: the partial symbol is discarded, no output.
//  Chip k of lane i is c = CDMA_CODES[CODE_BASE+i][k] (LSB first).
//   - c=0 adds channel, c=1 subtracts it (two's complement, sign-extended).
//  Accumulator: ACC_W = CH_W+LOG_CODE_LEN signed; no overflow possible.
//   - At chip 0: acc <= +/-channel. Otherwise: acc <= acc +/- channel.
//  Symbol complete on chip_valid at idx=CODE_LEN-1:
//   - The next cycle, decoded[i] <= (acc_final >>> LOG_CODE_LEN) truncated to DATA_WIDTH, and out_valid <= 1.
//   - Latency: last chip to out_valid is 1 cycle.
//  Handshake:
//   - out_valid&&out_ready clears out_valid next cycle.
//   - decoded holds stable while out_valid&&!out_ready.
//  Overrun: a new symbol completes while out_valid&&!out_ready.
//   - The new result overwrites decoded, out_valid stays 1, overrun <= 1.
//  Simultaneous accept and completion: the new result loads, out_valid stays 1, no overrun.
//  overrun_clr and a new overrun in the same cycle: overrun stays 1 (set wins).
//  Cycles without chip_valid: all state holds; a symbol may span any number of idle cycles.
//  rst mid-symbol: the partial symbol is discarded; the pending output is dropped; resumes at chip 0.
// STRUCTURE
//  AggrCDMAPkg provides DATA_WIDTH, LOG_CODE_WIDTH, CDMA_CODE_WIDTH and CDMA_CODES.
//  Add to AggrCDMAPkg: typedef for the lane-result array and a function acc_width(CH_W, LOG).
//  Sub-module cdma_decode_lane holds one code, one accumulator and the sign select; generated NUM_LANES times.
//  The top level owns the chip counter, the output register, the handshake and overrun.
// TESTING (NUM_LANES=2, CODE_LEN=4, codes lane0=4'b0000, lane1=4'b1010, DATA_WIDTH=8)
//  1 Basic: sym_start+chips 8,2,8,2 back-to-back, out_ready=1 -> out_valid 1 cycle after chip 3; decoded={3,5}.
//  2 Negative: chips 4,-8,4,-8 -> decoded lane0=-2, lane1=6.
//  3 Gaps: scenario 1 with 3 idle cycles between chips -> same result; out_valid only after the 4th chip.
//  4 Backpressure: out_ready=0 across two symbols (5,3 then -2,6) -> decoded={6,-2}, overrun=1.
//    Then overrun_clr -> overrun=0.
//  5 Resync: chips 8,2 then sym_start with 4,-8,4,-8 -> exactly one output, {6,-2}.
//  6 Reset: rst after chip 2 of a symbol, and also with out_valid held -> out_valid=0, decoded=0.
//    The next full symbol decodes correctly.

Source files
------------

// File: rtl/cdma_decoder_array_pkg.sv
// Shared constants, code table and types for the multi-lane CDMA despreader.
package cdma_decoder_array_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int CDMA_CODE_WIDTH = 4;
    localparam int LOG_CODE_WIDTH  = 2;
    localparam int NUM_CODES       = 4;

    // Walsh-style spreading codes, chip 0 in the LSB; entry 0 sits in the low bits.
    localparam logic [NUM_CODES-1:0][CDMA_CODE_WIDTH-1:0] CDMA_CODES = {
        4'b0110,
        4'b1100,
        4'b1010,
        4'b0000
    };

    // One decoded lane result; a lane-result array is lane_data_t [N-1:0], lane 0 in the LSBs.
    typedef logic signed [DATA_WIDTH-1:0] lane_data_t;

    // Accumulator width that can hold CODE_LEN full-scale samples without overflow.
    function automatic int acc_width(input int ch_w, input int log_len);
        return ch_w + log_len;
    endfunction

endpackage

// File: rtl/cdma_decoder_array_if.sv
// Chip input, decoded-result handshake and overrun status of the despreader.
interface cdma_decoder_array_if
    import cdma_decoder_array_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int CH_W      = DATA_WIDTH + LOG_CODE_WIDTH
);
    logic                        chip_valid;
    logic                        sym_start;
    logic signed [CH_W-1:0]      channel;
    logic                        out_valid;
    logic                        out_ready;
    lane_data_t [NUM_LANES-1:0]  decoded;
    logic                        overrun;
    logic                        overrun_clr;

    // Channel adder / consumer side.
    modport master (
        output chip_valid, sym_start, channel, out_ready, overrun_clr,
        input  out_valid, decoded, overrun
    );

    // Decoder side.
    modport slave (
        input  chip_valid, sym_start, channel, out_ready, overrun_clr,
        output out_valid, decoded, overrun
    );
endinterface

// File: rtl/cdma_decode_lane.sv
// One despreading lane: a fixed code, its sign select and a running accumulator.
module cdma_decode_lane
    import cdma_decoder_array_pkg::*;
#(
    parameter int                  CH_W         = DATA_WIDTH + LOG_CODE_WIDTH,
    parameter int                  LOG_CODE_LEN = LOG_CODE_WIDTH,
    parameter int                  CODE_LEN     = CDMA_CODE_WIDTH,
    parameter logic [CODE_LEN-1:0] CODE         = '0
) (
    input  logic                     clk,
    input  logic                     chip_valid,
    input  logic                     first,
    input  logic [LOG_CODE_LEN-1:0]  idx,
    input  logic signed [CH_W-1:0]   channel,
    output lane_data_t               result
);
    localparam int ACC_W = acc_width(CH_W, LOG_CODE_LEN);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ch_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_next;

    assign ch_ext = {{LOG_CODE_LEN{channel[CH_W-1]}}, channel};

    // Sign-select the sample by the current code chip and fold it into the running sum.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
        term     = ch_ext;
        acc_next = acc;
        if (CODE[idx]) term = -ch_ext;
        acc_next = first ? term : acc + term;
    end

    // Accumulate on valid chips only; chip 0 reloads, so no reset is needed here.
    always_ff @(posedge clk) begin
        // NOTE: the accumulator is deliberately not reset -- chip 0 always overwrites it, so its reset value is irrelevant.
        if (chip_valid) acc <= acc_next;
    end

    // Symbol value including the chip being accepted this cycle, scaled back by the code length.
    assign result = DATA_WIDTH'(acc_next >>> LOG_CODE_LEN);

endmodule

// File: rtl/cdma_decoder_array.sv
// Multi-lane CDMA despreader: shared chip counter, per-lane accumulators, output register with overrun.
module cdma_decoder_array
    import cdma_decoder_array_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int CODE_BASE    = 0,
    parameter int CODE_LEN     = CDMA_CODE_WIDTH,
    parameter int LOG_CODE_LEN = LOG_CODE_WIDTH,
    parameter int CH_W         = DATA_WIDTH + LOG_CODE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    cdma_decoder_array_if.slave   bus
);
    localparam logic [LOG_CODE_LEN-1:0] LAST_IDX = LOG_CODE_LEN'(CODE_LEN - 1);

    logic [LOG_CODE_LEN-1:0]    idx;
    logic [LOG_CODE_LEN-1:0]    idx_eff;
    logic                       first_chip;
    logic                       sym_done;
    logic                       out_valid;
    logic                       overrun;
    lane_data_t [NUM_LANES-1:0] decoded;
    lane_data_t [NUM_LANES-1:0] lane_res;

    // A resync chip is chip 0 regardless of where the counter stands.
    assign idx_eff    = (bus.chip_valid && bus.sym_start) ? '0 : idx;
    assign first_chip = (idx_eff == '0);
    assign sym_done   = bus.chip_valid && (idx_eff == LAST_IDX);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        cdma_decode_lane #(
            .CH_W         (CH_W),
            .LOG_CODE_LEN (LOG_CODE_LEN),
            .CODE_LEN     (CODE_LEN),
            .CODE         (CDMA_CODES[CODE_BASE + i])
        ) u_lane (
            .clk        (clk),
            .chip_valid (bus.chip_valid),
            .first      (first_chip),
            .idx        (idx_eff),
            .channel    (bus.channel),
            .result     (lane_res[i])
        );
    end

    // Chip counter, result register, valid/ready handshake and sticky overrun.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            idx       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            decoded   <= '0;
        end else begin
            if (bus.chip_valid) idx <= idx_eff + 1'b1;

            if (sym_done) begin
                decoded   <= lane_res;
                out_valid <= 1'b1;
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end

            if (sym_done && out_valid && !bus.out_ready) overrun <= 1'b1;
            else if (bus.overrun_clr)                    overrun <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.overrun   = overrun;
    assign bus.decoded   = decoded;

endmodule

// File: tb/tb_cdma_decoder_array.sv
// Self-checking bench: directed scenarios then random traffic against a symbol-level reference model.
module tb_cdma_decoder_array;
    import cdma_decoder_array_pkg::*;

    localparam int NL = 2;
    localparam int CW = DATA_WIDTH + LOG_CODE_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cdma_decoder_array_if #(.NUM_LANES(NL), .CH_W(CW)) bus ();

    cdma_decoder_array #(
        .NUM_LANES    (NL),
        .CODE_BASE    (0),
        .CODE_LEN     (4),
        .LOG_CODE_LEN (2),
        .CH_W         (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: chips of the symbol in flight and the expected outputs.
    int          chips[$];
    bit          exp_valid;
    bit          exp_overrun;
    logic [15:0] exp_dec;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Despread a full symbol from first principles: lane0 code 0000, lane1 code 1010, chip k at bit k.
    function automatic logic [15:0] despread();
        logic [3:0] codes [2];
        logic [15:0] r;
        codes[0] = 4'b0000;
        codes[1] = 4'b1010;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            int s = 0;
            for (int k = 0; k < 4; k++) s += codes[l][k] ? -chips[k] : chips[k];
            r[l*8 +: 8] = 8'(s >>> 2);
        end
        return r;
    endfunction

    task automatic model_step(input bit r, input bit cv, input bit ss, input int ch, input bit rdy, input bit clr);
        bit done = 1'b0;
        logic [15:0] res = '0;
        if (r) begin
            chips.delete();
            exp_valid = 1'b0; exp_overrun = 1'b0; exp_dec = '0;
            return;
        end
        if (cv) begin
            if (ss) chips.delete();
            chips.push_back(ch);
            if (chips.size() == 4) begin
                done = 1'b1;
                res  = despread();
                chips.delete();
            end
        end
        if (done && exp_valid && !rdy) exp_overrun = 1'b1;
        else if (clr)                  exp_overrun = 1'b0;
        if (done) begin
            exp_dec   = res;
            exp_valid = 1'b1;
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs (at negedge), clock it, and compare outputs on the following negedge.
    task automatic cycle(input bit r, input bit cv, input bit ss, input int ch, input bit rdy, input bit clr);
        rst             = r;
        bus.chip_valid  = cv;
        bus.sym_start   = ss;
        bus.channel     = CW'(ch);
        bus.out_ready   = rdy;
        bus.overrun_clr = clr;
        model_step(r, cv, ss, ch, rdy, clr);
        @(posedge clk);
        @(negedge clk);
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("overrun",   32'(bus.overrun),   32'(exp_overrun));
        check("decoded",   32'(bus.decoded),   32'(exp_dec));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, rdy, 1'b0);
    endtask

    task automatic send_sym(input int c0, input int c1, input int c2, input int c3,
                            input bit rdy, input int gap);
        int cs [4];
        cs = '{c0, c1, c2, c3};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, k == 0, cs[k], rdy, 1'b0);
            if (k < 3) idle(gap, rdy);
        end
    endtask

    initial begin
        bus.chip_valid = 1'b0; bus.sym_start = 1'b0; bus.channel = '0;
        bus.out_ready = 1'b0; bus.overrun_clr = 1'b0;
        exp_valid = 1'b0; exp_overrun = 1'b0; exp_dec = '0;
        @(negedge clk);

        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_dec",   32'(bus.decoded),   32'd0);

        // 1 Basic: valid exactly one cycle after chip 3, {3,5}.
        send_sym(8, 2, 8, 2, 1'b1, 0);
        check("basic_dec", 32'(bus.decoded), 32'({8'sd3, 8'sd5}));
        idle(1, 1'b1);
        check("basic_drop", 32'(bus.out_valid), 32'd0);

        // 2 Negative: lane0=-2, lane1=6.
        send_sym(4, -8, 4, -8, 1'b1, 0);
        check("neg_dec", 32'(bus.decoded), 32'({8'sd6, -8'sd2}));
        idle(1, 1'b1);

        // 3 Gaps: three idle cycles between chips, same result as basic.
        send_sym(8, 2, 8, 2, 1'b1, 3);
        check("gap_dec", 32'(bus.decoded), 32'({8'sd3, 8'sd5}));
        idle(2, 1'b1);

        // 4 Backpressure across two symbols, then clear.
        send_sym(8, 2, 8, 2, 1'b0, 0);
        idle(2, 1'b0);
        send_sym(4, -8, 4, -8, 1'b0, 1);
        check("bp_dec",     32'(bus.decoded), 32'({8'sd6, -8'sd2}));
        check("bp_overrun", 32'(bus.overrun), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        check("bp_clr", 32'(bus.overrun), 32'd0);
        idle(1, 1'b1);

        // 5 Resync: partial symbol discarded, exactly one output.
        cycle(1'b0, 1'b1, 1'b1, 8, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        check("resync_none", 32'(bus.out_valid), 32'd0);
        send_sym(4, -8, 4, -8, 1'b1, 0);
        check("resync_dec", 32'(bus.decoded), 32'({8'sd6, -8'sd2}));
        idle(2, 1'b1);

        // 6 Reset mid-symbol, and with a result held.
        cycle(1'b0, 1'b1, 1'b1, 8, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        send_sym(8, 2, 8, 2, 1'b0, 0);
        idle(1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_dec",   32'(bus.decoded),   32'd0);
        // Symbol without sym_start must still decode from chip 0 after reset.
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, (k % 2 == 0) ? 4 : -8, 1'b1, 1'b0);
        check("post_rst_dec", 32'(bus.decoded), 32'({8'sd6, -8'sd2}));

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            bit r   = ($urandom_range(0, 99) < 1);
            bit cv  = ($urandom_range(0, 99) < 60);
            bit ss  = cv && ($urandom_range(0, 99) < 5);
            int ch  = int'($urandom_range(0, 1023)) - 512;
            bit rdy = ($urandom_range(0, 99) < 50);
            bit clr = ($urandom_range(0, 99) < 10);
            cycle(r, cv, ss, ch, rdy, clr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
